// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared operation codes, sizing defaults and width helpers for the packer
package ara_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2,
        READ    = 2'd3
    } accel_op_e;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_KERNEL_SIZE = 9;
    localparam int DEF_NUM_OF_MUL  = 14;
    localparam int DEF_NUM_OF_SET  = 3;
    localparam int DEF_DATA_OF_SET = 128;
    localparam int DEF_NUM_OF_RES  = 8;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int slot_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - circular buffer of packed result words with their slot counts
module result_fifo
    import ara_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 4,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic [LEN_W-1:0]              push_len,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic [LEN_W-1:0]              head_len,
    output logic [slot_cnt_w(DEPTH)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = slot_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [LEN_W-1:0] mem_len  [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic             do_push, do_pop, empty;

    assign empty   = (count == '0);
    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else if (clear) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_data[tail_q] <= push_data;
            mem_len[tail_q]  <= push_len;
        end
    end

    assign head_data = empty ? '0 : mem_data[head_q];
    assign head_len  = empty ? '0 : mem_len[head_q];

endmodule

// File: rtl/output_packer.sv
// rtl/output_packer.sv - compacts adder-tree lanes into kernel-slot result words and buffers them
module output_packer
    import ara_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int NUM_OF_MUL  = DEF_NUM_OF_MUL,
    parameter int NUM_OF_SET  = DEF_NUM_OF_SET,
    parameter int DATA_OF_SET = DEF_DATA_OF_SET,
    parameter int NUM_OF_RES  = DEF_NUM_OF_RES
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_OF_SET-1:0]                       adder_valid,
    input  logic [NUM_OF_SET*NUM_OF_MUL*DATA_WIDTH-1:0] din,
    output logic                                        in_ready,
    input  accel_op_e                                   op,
    input  logic                                        flush,
    output logic [DATA_OF_SET*DATA_WIDTH-1:0]           res_data,
    output logic [slot_cnt_w(KERNEL_SIZE)-1:0]          res_len,
    output logic                                        res_valid,
    input  logic                                        res_ready,
    output logic [slot_cnt_w(NUM_OF_RES)-1:0]           res_count,
    output logic                                        full_flag
);

    localparam int SB = NUM_OF_MUL * DATA_WIDTH;
    localparam int WB = KERNEL_SIZE * SB;
    localparam int RB = DATA_OF_SET * DATA_WIDTH;
    localparam int LW = slot_cnt_w(KERNEL_SIZE);
    localparam int CW = slot_cnt_w(NUM_OF_RES);
    localparam int PW = $clog2(2 * KERNEL_SIZE + 1);

    if (KERNEL_SIZE * NUM_OF_MUL > DATA_OF_SET) begin : g_bad_word
        $error("output_packer: KERNEL_SIZE*NUM_OF_MUL exceeds DATA_OF_SET");
    end
    if (NUM_OF_SET < 1 || NUM_OF_SET > KERNEL_SIZE) begin : g_bad_lanes
        $error("output_packer: NUM_OF_SET must lie in 1..KERNEL_SIZE");
    end

    logic [KERNEL_SIZE-1:0][SB-1:0] asm_q, asm_d, cur_word, nxt_word;
    logic [NUM_OF_SET-1:0][SB-1:0]  lane_data;
    logic [NUM_OF_SET-1:0][PW-1:0]  lane_pos;
    logic [NUM_OF_SET-1:0]          lane_acc;
    logic [PW-1:0]                  total;
    logic [LW-1:0]                  fill_q, fill_d;
    logic                           pending_q, pending_d;
    logic                           is_write, push;
    logic [WB-1:0]                  push_data, head_data;
    logic [LW-1:0]                  push_len;
    logic [CW-1:0]                  count;

    assign lane_data = din;
    assign is_write  = (op == WRITE);
    assign in_ready  = (count < CW'(NUM_OF_RES)) && !pending_q;
    assign lane_acc  = (in_ready && !is_write) ? adder_valid : '0;

    // Running prefix count gives each accepted lane its absolute slot; slots past
    // KERNEL_SIZE spill into the next word.
    always_comb begin
        total = PW'(fill_q);
        for (int i = 0; i < NUM_OF_SET; i++) begin
            lane_pos[i] = total;
            total       = total + PW'(lane_acc[i]);
        end
    end

    always_comb begin
        cur_word = asm_q;
        nxt_word = '0;
        for (int s = 0; s < KERNEL_SIZE; s++) begin
            for (int i = 0; i < NUM_OF_SET; i++) begin
                if (lane_acc[i] && lane_pos[i] == PW'(s))
                    cur_word[s] = lane_data[i];
                if (lane_acc[i] && lane_pos[i] == PW'(s + KERNEL_SIZE))
                    nxt_word[s] = lane_data[i];
            end
        end
    end

    // Slots at or above fill are kept zero so a flushed partial word reads clean.
    always_comb begin
        asm_d     = asm_q;
        fill_d    = fill_q;
        pending_d = pending_q;
        push      = 1'b0;
        push_data = '0;
        push_len  = '0;
        if (is_write) begin
            asm_d     = '0;
            fill_d    = '0;
            pending_d = 1'b0;
        end else begin
            if (pending_q) begin
                if (count < CW'(NUM_OF_RES)) begin
                    push      = (fill_q != '0);
                    push_data = asm_q;
                    push_len  = fill_q;
                    asm_d     = '0;
                    fill_d    = '0;
                    pending_d = 1'b0;
                end
            end else if (total >= PW'(KERNEL_SIZE)) begin
                push      = 1'b1;
                push_data = cur_word;
                push_len  = LW'(KERNEL_SIZE);
                asm_d     = nxt_word;
                fill_d    = LW'(total - PW'(KERNEL_SIZE));
            end else begin
                asm_d  = cur_word;
                fill_d = LW'(total);
            end
            if (flush) pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q     <= '0;
            fill_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            fill_q    <= fill_d;
            pending_q <= pending_d;
        end
    end

    result_fifo #(
        .WIDTH (WB),
        .LEN_W (LW),
        .DEPTH (NUM_OF_RES)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (is_write),
        .push      (push),
        .push_data (push_data),
        .push_len  (push_len),
        .pop       (res_ready && !is_write),
        .head_data (head_data),
        .head_len  (res_len),
        .count     (count)
    );

    assign res_data  = RB'(head_data);
    assign res_valid = (count != '0);
    assign res_count = count;
    assign full_flag = (count == CW'(NUM_OF_RES));

endmodule

// File: tb/tb_output_packer.sv
// tb/tb_output_packer.sv - directed bench with a slot-queue reference model for output_packer
module tb_output_packer;
    import ara_pkg::*;

    localparam int W  = 32;
    localparam int K  = 9;
    localparam int M  = 14;
    localparam int S  = 3;
    localparam int DS = 128;
    localparam int N  = 8;
    localparam int SB = M * W;
    localparam int RB = DS * W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [S-1:0]    adder_valid = '0;
    logic [S*SB-1:0] din = '0;
    logic            in_ready;
    accel_op_e       op = IDLE;
    logic            flush = 1'b0;
    logic [RB-1:0]   res_data;
    logic [3:0]      res_len;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [3:0]      res_count;
    logic            full_flag;

    int n_tests = 0;
    int n_fail  = 0;

    output_packer dut (
        .clk         (clk),
        .rst         (rst),
        .adder_valid (adder_valid),
        .din         (din),
        .in_ready    (in_ready),
        .op          (op),
        .flush       (flush),
        .res_data    (res_data),
        .res_len     (res_len),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .full_flag   (full_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [SB-1:0] mk_slot(input int tag);
        logic [SB-1:0] s;
        for (int e = 0; e < M; e++) s[e*W +: W] = (tag << 16) | e;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] elem(input int slot, input int e);
        return res_data[(slot*M + e)*W +: W];
    endfunction

    // Reference: a flat queue of accepted slots, cut into words of K as it fills.
    logic [SB-1:0] m_part  [$];
    logic [RB-1:0] m_words [$];
    int            m_lens  [$];
    bit            m_pend;
    int            m_sz;
    bit            m_pop;

    task automatic emit(input int n);
        logic [RB-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*SB +: SB] = m_part.pop_front();
        m_words.push_back(w);
        m_lens.push_back(n);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst || op == WRITE) begin
            m_part.delete();
            m_words.delete();
            m_lens.delete();
            m_pend = 1'b0;
        end else begin
            m_sz  = m_words.size();
            m_pop = res_ready && (m_sz > 0);
            if (m_pend) begin
                if (m_sz < N) begin
                    if (m_part.size() > 0) emit(m_part.size());
                    m_pend = 1'b0;
                end
            end else if (m_sz < N) begin
                for (int l = 0; l < S; l++)
                    if (adder_valid[l]) m_part.push_back(din[l*SB +: SB]);
                if (m_part.size() >= K) emit(K);
            end
            if (flush) m_pend = 1'b1;
            if (m_pop) begin
                void'(m_words.pop_front());
                void'(m_lens.pop_front());
            end
        end
    end

    logic [RB-1:0] exp_data;
    int            bad_e;
    always @(negedge clk) begin
        exp_data = (m_words.size() > 0) ? m_words[0] : '0;
        chk("res_valid", res_valid, m_words.size() > 0);
        chk("res_count", res_count, m_words.size());
        chk("full_flag", full_flag, m_words.size() == N);
        chk("in_ready", in_ready, (m_words.size() < N) && !m_pend);
        chk("res_len", res_len, (m_lens.size() > 0) ? m_lens[0] : 0);
        n_tests++;
        if (res_data !== exp_data) begin
            n_fail++;
            bad_e = 0;
            for (int e = DS - 1; e >= 0; e--)
                if (res_data[e*W +: W] !== exp_data[e*W +: W]) bad_e = e;
            $display("FAIL res_data elem %0d got %h exp %h at %0t", bad_e,
                     res_data[bad_e*W +: W], exp_data[bad_e*W +: W], $time);
        end
    end

    task automatic step(input logic [S-1:0] v, input int base, input logic fl,
                        input logic rr, input accel_op_e o);
        adder_valid = v;
        for (int l = 0; l < S; l++) din[l*SB +: SB] = mk_slot(base + l);
        flush     = fl;
        res_ready = rr;
        op        = o;
        @(posedge clk);
        #1;
        adder_valid = '0;
        flush       = 1'b0;
        res_ready   = 1'b0;
        op          = IDLE;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_count", res_count, 0);

        // Three full lane sets form exactly one word.
        step(3'b111, 10, 0, 0, IDLE);
        step(3'b111, 20, 0, 0, IDLE);
        step(3'b111, 30, 0, 0, IDLE);
        chk("w1_len", res_len, 9);
        chk("w1_slot4", elem(4, 0), 32'h0015_0000);
        chk("w1_slot8", elem(8, 13), 32'h0020_000D);
        chk("w1_e126", res_data[126*W +: W], 0);
        chk("w1_e127", res_data[127*W +: W], 0);
        step(3'b000, 0, 0, 1, IDLE);
        chk("w1_popped", res_count, 0);

        // Sparse lanes 0 and 2: ninth slot lands on the fifth cycle, one spills.
        for (int c = 0; c < 5; c++) begin
            step(3'b101, 40 + 10*c, 0, 0, IDLE);
            if (c == 3) chk("sparse_c4_count", res_count, 0);
        end
        chk("sparse_count", res_count, 1);
        chk("sparse_slot1", elem(1, 0), 32'h002A_0000);
        chk("sparse_slot8", elem(8, 0), 32'h0050_0000);
        step(3'b000, 0, 1, 0, IDLE);
        step(3'b000, 0, 0, 1, IDLE);
        chk("spill_count", res_count, 1);
        chk("spill_len", res_len, 1);
        chk("spill_slot0", elem(0, 0), 32'h0052_0000);
        step(3'b000, 0, 0, 1, IDLE);

        // Fill all eight entries, then offer lanes that must be refused.
        step(3'b000, 0, 0, 0, WRITE);
        for (int c = 0; c < 24; c++) step(3'b111, 100 + 4*c, 0, 0, IDLE);
        chk("full_flag", full_flag, 1);
        chk("full_in_ready", in_ready, 0);
        step(3'b111, 900, 0, 0, IDLE);
        step(3'b111, 910, 0, 0, IDLE);
        chk("full_count", res_count, 8);
        step(3'b000, 0, 0, 1, IDLE);
        chk("after_pop_ready", in_ready, 1);
        step(3'b000, 0, 0, 0, WRITE);

        // Partial flush of four slots, then a flush with nothing held.
        for (int c = 0; c < 4; c++) step(3'b001, 200 + 10*c, 0, 0, IDLE);
        step(3'b000, 0, 1, 0, IDLE);
        step(3'b000, 0, 0, 0, IDLE);
        chk("flush_count", res_count, 1);
        chk("flush_len", res_len, 4);
        chk("flush_slot3", elem(3, 0), 32'h00E6_0000);
        chk("flush_slot4", elem(4, 0), 0);
        step(3'b000, 0, 1, 0, IDLE);
        step(3'b000, 0, 0, 0, IDLE);
        step(3'b000, 0, 0, 0, IDLE);
        chk("empty_flush_count", res_count, 1);

        // Flush arriving with lanes that complete a word keeps the overflow.
        step(3'b000, 0, 0, 0, WRITE);
        step(3'b111, 300, 0, 0, IDLE);
        step(3'b111, 310, 0, 0, IDLE);
        step(3'b001, 320, 0, 0, IDLE);
        step(3'b111, 330, 1, 0, IDLE);
        step(3'b000, 0, 0, 0, IDLE);
        chk("flush_lanes_count", res_count, 2);
        step(3'b000, 0, 0, 1, IDLE);
        chk("flush_lanes_len", res_len, 1);
        chk("flush_lanes_slot0", elem(0, 0), 32'h014C_0000);

        // Push and pop in one cycle, then WRITE with a pop request.
        step(3'b000, 0, 0, 0, WRITE);
        for (int c = 0; c < 9; c++) step(3'b111, 400 + 4*c, 0, 0, IDLE);
        step(3'b111, 450, 0, 0, IDLE);
        step(3'b111, 460, 0, 0, IDLE);
        step(3'b111, 470, 0, 1, IDLE);
        chk("pushpop_count", res_count, 3);
        step(3'b111, 480, 0, 1, WRITE);
        chk("write_count", res_count, 0);
        chk("write_valid", res_valid, 0);

        // Reset with two words stored and five slots pending.
        for (int c = 0; c < 6; c++) step(3'b111, 600 + 4*c, 0, 0, IDLE);
        step(3'b111, 700, 0, 0, IDLE);
        step(3'b011, 710, 0, 0, IDLE);
        rst = 1'b0;
        #2;
        chk("rst_valid", res_valid, 0);
        chk("rst_count", res_count, 0);
        chk("rst_len", res_len, 0);
        chk("rst_full", full_flag, 0);
        chk("rst_data", {31'd0, |res_data}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(3'b111, 500, 0, 0, IDLE);
        step(3'b000, 0, 1, 0, IDLE);
        step(3'b000, 0, 0, 0, IDLE);
        chk("post_rst_len", res_len, 3);
        chk("post_rst_slot0", elem(0, 0), 32'h01F4_0000);
        step(3'b000, 0, 0, 1, IDLE);
        step(3'b000, 0, 0, 0, IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_packer.md
OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning element width in bits.
REQ-002 SHALL have parameter KERNEL_SIZE, default 9, meaning number of kernel slots per packed result word.
REQ-003 SHALL have parameter NUM_OF_MUL, default 14, meaning elements per slot.
REQ-004 SHALL have parameter NUM_OF_SET, default 3, meaning input lanes from the adder trees, 1..KERNEL_SIZE.
REQ-005 SHALL have parameter DATA_OF_SET, default 128, meaning elements per result word; KERNEL_SIZE*NUM_OF_MUL <= DATA_OF_SET, checked at elaboration.
REQ-006 SHALL have parameter NUM_OF_RES, default 8, meaning result buffer depth (power of two).
REQ-007 SHALL use one clock; reset is asynchronous and active-low.
REQ-008 Port: clk  in  1  clock, all state on rising edge.
REQ-009 Port: rst  in  1  asynchronous active-low reset.
REQ-010 Port: adder_valid  in  NUM_OF_SET  per-lane valid.
REQ-011 Port: din  in  NUM_OF_SET x NUM_OF_MUL x DATA_WIDTH  lane data.
REQ-012 Port: in_ready  out  1  lanes accepted this cycle when high.
REQ-013 Port: op  in  accel_op_e  operation; WRITE clears the block synchronously.
REQ-014 Port: flush  in  1  pulse; emit the partially filled word.
REQ-015 Port: res_data  out  DATA_OF_SET x DATA_WIDTH  head result word.
REQ-016 Port: res_len  out  clog2(KERNEL_SIZE+1)  valid slots in res_data.
REQ-017 Port: res_valid  out  1  buffer non-empty.
REQ-018 Port: res_ready  in  1  consumer pops the head when high with res_valid.
REQ-019 Port: res_count  out  clog2(NUM_OF_RES+1)  stored words.
REQ-020 Port: full_flag  out  1  res_count == NUM_OF_RES.

Function
REQ-021 Accepted lanes SHALL be compacted in ascending lane order, for any adder_valid pattern, into the next free slots of the assembly word; idle lanes consume no slot.
REQ-022 in_ready SHALL equal (res_count < NUM_OF_RES) and not flush_pending; when in_ready is low, adder_valid SHALL be ignored.
REQ-023 When fill + popcount(adder_valid) >= KERNEL_SIZE, the completed word (res_len = KERNEL_SIZE) SHALL be pushed that cycle, and overflow lanes SHALL start the next word at slot 0 with no loss.
REQ-024 Unused element positions (slots >= res_len, elements >= KERNEL_SIZE*NUM_OF_MUL) SHALL read zero.
REQ-025 A pushed word SHALL be visible on res_data/res_valid the cycle after the push edge (one-cycle latency).
REQ-026 flush SHALL set a sticky flush_pending; while pending and res_count < NUM_OF_RES, one partial word (res_len = fill) SHALL be pushed if fill > 0, fill cleared, and pending cleared; fill == 0 SHALL clear pending without pushing.
REQ-027 flush asserted while in_ready was high SHALL NOT drop that cycle's accepted lanes; they are included in the flushed word or in a full word pushed first.
REQ-028 Push and pop in the same cycle SHALL leave res_count unchanged; pop with res_valid low SHALL be ignored.
REQ-029 Head/tail pointers SHALL wrap modulo NUM_OF_RES.
REQ-030 op == WRITE SHALL clear fill, flush_pending, pointers and res_count on the next edge, discarding input that cycle; a simultaneous pop SHALL have no effect.

Reset
REQ-031 On rst low: res_valid=0, res_count=0, full_flag=0, res_len=0, res_data=0, in_ready=1 after release, fill=0, flush_pending=0, pointers=0.
REQ-032 Reset mid-word SHALL discard the partial word and all buffered words.

Structure
REQ-033 Sizing constants and the slot-count width function SHALL reside in ara_pkg alongside accel_op_e.
REQ-034 The circular result buffer SHALL be one sub-module, result_fifo (push, pop, count, data+len).
REQ-035 The compaction (prefix popcount) SHALL be combinational in output_packer; no multi-cycle path.

Verification
REQ-036 Defaults, adder_valid=111 for 3 cycles with distinct data -> one push, res_len=9, slots 0..8 in arrival/lane order, elements 126..127 zero.
REQ-037 adder_valid 101 ×5 -> word 1 pushed on 5th cycle with lane0/lane2 order alternating, fill=1 afterwards.
REQ-038 8 full words with res_ready=0 -> full_flag=1, in_ready=0, 9th word's lanes not accepted; one pop -> in_ready=1 next cycle.
REQ-039 Fill=4, flush pulse -> one word res_len=4, slots 4..8 zero; second flush with fill=0 -> no push.
REQ-040 res_count=3, push and pop same cycle -> res_count stays 3; op=WRITE -> res_count=0, res_valid=0 next cycle.
REQ-041 rst low with fill=5 and res_count=2 -> all outputs at reset values; post-release fill starts at slot 0.
